// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART 8N1 receiver and 4-byte command-frame parser driving the meter control registers
module uart_cmd_rx #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter int         TIMEOUT_CLKS = 2_500_000,
  parameter logic [1:0] GATE_SEL_RST = 2'b01
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic       Uart_Rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [1:0] gate_sel,
  output logic       ch_sel,
  output logic       meas_start,
  output logic       tx_req,
  output logic       cmd_err,
  output logic       busy
);
  localparam int CW = ($clog2(CLKS_PER_BIT) > 16) ? $clog2(CLKS_PER_BIT) : 16;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] HDR = 8'hAA;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} rx_state_t;
  typedef enum logic [1:0] {P_HDR, P_CMD, P_DAT, P_CHK} p_state_t;
  logic            r_sync1, r_sync2, r_sync3;
  logic            w_rx, w_fall;
  rx_state_t       r_rx_st, w_rx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            w_rx_done, w_frm_err;
  logic [7:0]      r_rx_byte;
  logic            r_rx_valid;
  p_state_t        r_p_st, w_p_nxt;
  logic [7:0]      r_cmd, w_cmd_nxt, r_dat, w_dat_nxt;
  logic [TW-1:0]   r_tcnt, w_tcnt_nxt;
  logic            w_chk_ok, w_chk_bad;
  logic            w_gate_wr, w_ch_wr, w_meas, w_txr, w_bad_cmd;
  logic [1:0]      r_gate;
  logic            r_ch, r_meas, r_txr, r_err;
  assign w_rx = r_sync2;
  assign w_fall = r_sync3 & ~r_sync2;
  // Two-flop synchroniser on the asynchronous line plus a delayed copy for edge detection
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= Uart_Rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end
  // Receiver next-state: mid-bit sampling timed by the baud counter, LSB first
  always_comb begin
    w_rx_nxt = r_rx_st;
    w_cnt_nxt = r_cnt + CW'(1);
    w_bit_nxt = r_bit;
    w_shift_nxt = r_shift;
    w_rx_done = 1'b0;
    w_frm_err = 1'b0;
    case (r_rx_st)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_rx_nxt = w_fall ? S_START : S_IDLE;
      end
      S_START: if (r_cnt == HALF_END) begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        w_rx_nxt = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: if (r_cnt == BIT_END) begin
        w_cnt_nxt = '0;
        w_shift_nxt = {w_rx, r_shift[7:1]};
        w_bit_nxt = r_bit + 3'd1;
        w_rx_nxt = (r_bit == 3'd7) ? S_STOP : S_DATA;
      end
      S_STOP: if (r_cnt == BIT_END) begin
        w_cnt_nxt = '0;
        w_rx_done = w_rx;
        w_frm_err = !w_rx;
        w_rx_nxt = w_rx ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = '0;
        w_rx_nxt = w_rx ? S_IDLE : S_WAIT;
      end
      default: w_rx_nxt = S_IDLE;
    endcase
  end
  // Receiver state, counters and the received-byte strobe
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      r_rx_st <= S_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_rx_byte <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_st <= w_rx_nxt;
      r_cnt <= w_cnt_nxt;
      r_bit <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_rx_byte <= w_rx_done ? r_shift : r_rx_byte;
      r_rx_valid <= w_rx_done;
    end
  end
  // Parser next-state: header hunt, CMD/DATA capture, checksum, inter-byte timeout
  always_comb begin
    w_p_nxt = r_p_st;
    w_cmd_nxt = r_cmd;
    w_dat_nxt = r_dat;
    w_tcnt_nxt = (r_p_st == P_HDR || r_rx_valid) ? '0 : r_tcnt + TW'(1);
    w_chk_ok = 1'b0;
    w_chk_bad = 1'b0;
    if (w_frm_err) begin
      w_p_nxt = P_HDR;
    end else if (r_rx_valid) begin
      case (r_p_st)
        P_HDR: w_p_nxt = (r_rx_byte == HDR) ? P_CMD : P_HDR;
        P_CMD: begin
          w_cmd_nxt = r_rx_byte;
          w_p_nxt = P_DAT;
        end
        P_DAT: begin
          w_dat_nxt = r_rx_byte;
          w_p_nxt = P_CHK;
        end
        P_CHK: begin
          w_chk_ok = r_rx_byte == (r_cmd ^ r_dat);
          w_chk_bad = r_rx_byte != (r_cmd ^ r_dat);
          w_p_nxt = P_HDR;
        end
        default: w_p_nxt = P_HDR;
      endcase
    end else if (r_p_st != P_HDR && r_tcnt == TO_END) begin
      w_p_nxt = P_HDR;
    end
  end
  assign w_gate_wr = w_chk_ok && r_cmd == 8'h01 && r_dat[1:0] != 2'b11;
  assign w_ch_wr = w_chk_ok && r_cmd == 8'h02;
  assign w_meas = w_chk_ok && r_cmd == 8'h03;
  assign w_txr = w_chk_ok && r_cmd == 8'h04;
  assign w_bad_cmd = w_chk_ok && !(w_gate_wr || w_ch_wr || w_meas || w_txr);
  // Parser state and the control registers/pulses, one cycle after the CHK strobe
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      r_p_st <= P_HDR;
      r_cmd <= '0;
      r_dat <= '0;
      r_tcnt <= '0;
      r_gate <= GATE_SEL_RST;
      r_ch <= 1'b0;
      r_meas <= 1'b0;
      r_txr <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_p_st <= w_p_nxt;
      r_cmd <= w_cmd_nxt;
      r_dat <= w_dat_nxt;
      r_tcnt <= w_tcnt_nxt;
      r_gate <= w_gate_wr ? r_dat[1:0] : r_gate;
      r_ch <= w_ch_wr ? r_dat[0] : r_ch;
      r_meas <= w_meas;
      r_txr <= w_txr;
      r_err <= w_frm_err | w_chk_bad | w_bad_cmd;
    end
  end
  assign rx_byte = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign gate_sel = r_gate;
  assign ch_sel = r_ch;
  assign meas_start = r_meas;
  assign tx_req = r_txr;
  assign cmd_err = r_err;
  assign busy = (r_rx_st != S_IDLE) || (r_p_st != P_HDR);
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: frame table, multi-cycle corner sequences and randomized byte stream against a frame-level model
module tb_uart_cmd_rx;
  localparam int CPB = 16;
  localparam int TO = 1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1;
  logic [7:0] rx_byte;
  logic rx_valid;
  logic [1:0] gate_sel;
  logic ch_sel, meas_start, tx_req, cmd_err, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0, n_meas = 0, n_tx = 0, n_err = 0, n_excl = 0;
  int last_valid_cyc = 0, gate_chg_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  logic [1:0] prev_gate;
  int b_valid, b_meas, b_tx, b_err;
  logic [1:0] m_gate;
  logic m_ch;
  int m_meas, m_tx, m_err;
  logic [7:0] frm[$];
  typedef struct {
    logic [31:0] frame;
    logic [1:0]  gate;
    logic        ch;
    int          meas;
    int          tx;
    int          err;
  } vec_t;
  vec_t vecs[10];
  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .Sys_CLK(clk),
    .Sys_RST(rst_n),
    .Uart_Rx(rx_line),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .gate_sel(gate_sel),
    .ch_sel(ch_sel),
    .meas_start(meas_start),
    .tx_req(tx_req),
    .cmd_err(cmd_err),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      last_byte = rx_byte;
      last_valid_cyc = cyc;
    end
    if (meas_start === 1'b1) n_meas++;
    if (tx_req === 1'b1) n_tx++;
    if (cmd_err === 1'b1) n_err++;
    if (int'(meas_start === 1'b1) + int'(tx_req === 1'b1) + int'(cmd_err === 1'b1) > 1) n_excl++;
    if (gate_sel !== prev_gate) gate_chg_cyc = cyc;
    prev_gate = gate_sel;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic snap();
    b_valid = n_valid;
    b_meas = n_meas;
    b_tx = n_tx;
    b_err = n_err;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
  endtask
  task automatic send_frame(input logic [31:0] f);
    for (int j = 0; j < 4; j++) send_byte(f[31-8*j -: 8]);
  endtask
  task automatic model_byte(input logic [7:0] b);
    if (frm.size() == 0 && b != 8'hAA) return;
    frm.push_back(b);
    if (frm.size() < 4) return;
    if (frm[3] != (frm[1] ^ frm[2])) m_err++;
    else if (frm[1] == 8'h01 && frm[2][1:0] != 2'b11) m_gate = frm[2][1:0];
    else if (frm[1] == 8'h02) m_ch = frm[2][0];
    else if (frm[1] == 8'h03) m_meas++;
    else if (frm[1] == 8'h04) m_tx++;
    else m_err++;
    frm.delete();
  endtask
  task automatic check_deltas(input string tag, input int dv, input int dm, input int dt, input int de);
    check({tag, "_valid"}, n_valid - b_valid, dv);
    check({tag, "_meas"}, n_meas - b_meas, dm);
    check({tag, "_tx"}, n_tx - b_tx, dt);
    check({tag, "_err"}, n_err - b_err, de);
  endtask
  initial begin
    logic [7:0] q[$];
    logic [1:0] exp_gate;
    int t0, lat, kind;
    logic [7:0] c, d, k;
    vecs[0] = '{32'hAA010203, 2'b10, 1'b0, 0, 0, 0};
    vecs[1] = '{32'hAA030003, 2'b10, 1'b0, 1, 0, 0};
    vecs[2] = '{32'hAA040005, 2'b10, 1'b0, 0, 0, 1};
    vecs[3] = '{32'hAA040004, 2'b10, 1'b0, 0, 1, 0};
    vecs[4] = '{32'hAA010302, 2'b10, 1'b0, 0, 0, 1};
    vecs[5] = '{32'hAA070007, 2'b10, 1'b0, 0, 0, 1};
    vecs[6] = '{32'hAA020103, 2'b10, 1'b1, 0, 0, 0};
    vecs[7] = '{32'hAA010001, 2'b00, 1'b1, 0, 0, 0};
    vecs[8] = '{32'hAA020002, 2'b00, 1'b0, 0, 0, 0};
    vecs[9] = '{32'hAAAA01AB, 2'b00, 1'b0, 0, 0, 1};
    repeat (3) @(negedge clk);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_gate", gate_sel, 2'b01);
    check("rst_ch", ch_sel, 1'b0);
    check("rst_meas", meas_start, 1'b0);
    check("rst_tx", tx_req, 1'b0);
    check("rst_err", cmd_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    snap();
    t0 = cyc;
    send_byte(8'h5A);
    repeat (4) @(negedge clk);
    lat = last_valid_cyc - t0;
    check("b5a_valid", n_valid - b_valid, 1);
    check("b5a_byte", rx_byte, 8'h5A);
    check("b5a_latency_in_window", (lat >= 153 && lat <= 155), 1'b1);
    check("b5a_err", n_err - b_err, 0);
    exp_gate = 2'b01;
    for (int i = 0; i < 10; i++) begin
      snap();
      send_frame(vecs[i].frame);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_gate", i), gate_sel, vecs[i].gate);
      check($sformatf("v%0d_ch", i), ch_sel, vecs[i].ch);
      check_deltas($sformatf("v%0d", i), 4, vecs[i].meas, vecs[i].tx, vecs[i].err);
      if (vecs[i].gate != exp_gate) check($sformatf("v%0d_gate_lat", i), gate_chg_cyc - last_valid_cyc, 1);
      exp_gate = vecs[i].gate;
    end
    check("last_frame_byte", rx_byte, 8'hAB);
    snap();
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_deltas("glitch", 0, 0, 0, 0);
    check("glitch_busy", busy, 1'b0);
    snap();
    send_byte(8'h3C, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check_deltas("frm", 0, 0, 0, 1);
    check("frm_rx_byte_kept", rx_byte, 8'hAB);
    check("frm_busy", busy, 1'b0);
    snap();
    send_byte(8'h81);
    repeat (4) @(negedge clk);
    check("after_frm_valid", n_valid - b_valid, 1);
    check("after_frm_byte", last_byte, 8'h81);
    snap();
    send_byte(8'hAA);
    send_byte(8'h3C, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (4) @(negedge clk);
    check_deltas("midfrm", 4, 0, 0, 1);
    check("midfrm_gate", gate_sel, 2'b00);
    snap();
    send_byte(8'hAA);
    send_byte(8'h02);
    repeat (900) @(negedge clk);
    check("to_busy_before", busy, 1'b1);
    repeat (300) @(negedge clk);
    check("to_busy_after", busy, 1'b0);
    send_byte(8'h01);
    send_byte(8'h03);
    repeat (4) @(negedge clk);
    check("to_ch", ch_sel, 1'b0);
    check_deltas("to", 4, 0, 0, 0);
    snap();
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h01);
    rx_line = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("mrst_ch", ch_sel, 1'b0);
    check("mrst_gate", gate_sel, 2'b01);
    check("mrst_busy", busy, 1'b0);
    check_deltas("mrst", 3, 0, 0, 0);
    snap();
    send_frame(32'hAA020103);
    repeat (4) @(negedge clk);
    check("mrst_next_ch", ch_sel, 1'b1);
    check_deltas("mrst_next", 4, 0, 0, 0);
    m_gate = 2'b01;
    m_ch = 1'b1;
    frm.delete();
    for (int it = 0; it < 40; it++) begin
      snap();
      m_meas = 0;
      m_tx = 0;
      m_err = 0;
      q.delete();
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        q.push_back(8'($urandom));
      end else begin
        c = 8'($urandom_range(0, 5));
        d = 8'($urandom);
        k = c ^ d;
        if ($urandom_range(0, 4) == 0) k = k ^ (8'h01 << $urandom_range(0, 7));
        q.push_back(8'hAA);
        q.push_back(c);
        q.push_back(d);
        q.push_back(k);
      end
      foreach (q[j]) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(q[j]);
        model_byte(q[j]);
      end
      repeat (4) @(negedge clk);
      check($sformatf("r%0d_gate", it), gate_sel, m_gate);
      check($sformatf("r%0d_ch", it), ch_sel, m_ch);
      check($sformatf("r%0d_last", it), last_byte, q[q.size()-1]);
      check_deltas($sformatf("r%0d", it), q.size(), m_meas, m_tx, m_err);
    end
    repeat (TO + 100) @(negedge clk);
    frm.delete();
    check("rand_end_busy", busy, 1'b0);
    check("one_pulse_per_cycle", n_excl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
